// File: rtl/roce_dma_pkg.sv
// Shared types and helpers for the RoCE memory-write gate.
//
// Contents:
//   mem_cmd_t   - write command layout: {len[31:0], addr[63:0]} (96 bits)
//   DATA_BYTES  - bytes per data beat (64)
//   CMD_W       - command word width (96)
//   last_keep() - final-beat byte-enable mask derived from the command length
package roce_dma_pkg;

  localparam int unsigned DATA_BYTES = 64;
  localparam int unsigned CMD_W      = 96;

  typedef struct packed {
    logic [31:0] len;
    logic [63:0] addr;
  } mem_cmd_t;

  // A length that is a whole number of beats leaves the final beat fully enabled.
  function automatic logic [DATA_BYTES-1:0] last_keep(input logic [31:0] len);
    logic [DATA_BYTES-1:0] mask;
    if (len[5:0] == 6'd0) begin
      mask = '1;
    end else begin
      mask = (64'd1 << len[5:0]) - 64'd1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/roce_mem_write_gate_if.sv
// Bus bundle around roce_mem_write_gate.
//
// Carries both sides of the gate:
//   s_cmd_*  / s_data_*  - command and data streams from the RoCE stack
//   m_cmd_*  / m_data_*  - command and data streams to the host DMA write channel
// Modports:
//   slave  - the gate itself (consumes s_*, produces m_*)
//   master - the surrounding environment (produces s_*, consumes m_*)
interface roce_mem_write_gate_if
  import roce_dma_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEST_W = 4
) ();

  logic                s_cmd_valid;
  logic                s_cmd_ready;
  logic [CMD_W-1:0]    s_cmd_data;
  logic [DEST_W-1:0]   s_cmd_dest;

  logic                s_data_valid;
  logic                s_data_ready;
  logic [DATA_W-1:0]   s_data_data;
  logic [DATA_W/8-1:0] s_data_keep;
  logic                s_data_last;

  logic                m_cmd_valid;
  logic                m_cmd_ready;
  logic [CMD_W-1:0]    m_cmd_data;
  logic [DEST_W-1:0]   m_cmd_dest;

  logic                m_data_valid;
  logic                m_data_ready;
  logic [DATA_W-1:0]   m_data_data;
  logic [DATA_W/8-1:0] m_data_keep;
  logic                m_data_last;
  logic [DEST_W-1:0]   m_data_dest;

  modport slave (
    input  s_cmd_valid, s_cmd_data, s_cmd_dest,
    input  s_data_valid, s_data_data, s_data_keep, s_data_last,
    input  m_cmd_ready, m_data_ready,
    output s_cmd_ready, s_data_ready,
    output m_cmd_valid, m_cmd_data, m_cmd_dest,
    output m_data_valid, m_data_data, m_data_keep, m_data_last, m_data_dest
  );

  modport master (
    output s_cmd_valid, s_cmd_data, s_cmd_dest,
    output s_data_valid, s_data_data, s_data_keep, s_data_last,
    output m_cmd_ready, m_data_ready,
    input  s_cmd_ready, s_data_ready,
    input  m_cmd_valid, m_cmd_data, m_cmd_dest,
    input  m_data_valid, m_data_data, m_data_keep, m_data_last, m_data_dest
  );

endinterface

// File: rtl/roce_mem_write_gate.sv
// RoCE memory-write gate.
//
// Pairs each write command from the RoCE stack with its data beats, issues the
// command to the DMA write channel before any data, forwards exactly
// ceil(len/64) beats with regenerated TLAST / final-beat TKEEP, and reports
// short or long upstream bursts. Long bursts are drained; short bursts are
// terminated early and only reported.
//
// Ports:
//   net_clk    - clock
//   net_reset  - synchronous active-high reset
//   bus        - roce_mem_write_gate_if.slave (s_cmd/s_data in, m_cmd/m_data out)
//   err_short  - 1-cycle pulse: upstream TLAST arrived before the expected beat count
//   err_long   - 1-cycle pulse: expected beat count reached without upstream TLAST
//   cmd_count  - accepted commands, saturating (ROCE_WR_STATS_EN only, else 0)
//   err_count  - short+long errors, saturating (ROCE_WR_STATS_EN only, else 0)
//
// Build option: define ROCE_WR_STATS_EN to include the statistics counters.
module roce_mem_write_gate
  import roce_dma_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEST_W = 4
) (
  input  logic                 net_clk,
  input  logic                 net_reset,
  roce_mem_write_gate_if.slave bus,
  output logic                 err_short,
  output logic                 err_long,
  output logic [31:0]          cmd_count,
  output logic [31:0]          err_count
);

  localparam int unsigned KeepW = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDrain
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  mem_cmd_t           r_cmd;
  mem_cmd_t           w_cmd_next;
  logic [DEST_W-1:0]  r_dest;
  logic [DEST_W-1:0]  w_dest_next;
  logic [26:0]        r_beats_left;
  logic [26:0]        w_beats_next;
  logic               r_err_short;
  logic               r_err_long;
  logic               w_err_short_next;
  logic               w_err_long_next;

  mem_cmd_t           w_s_cmd;
  logic [26:0]        w_beats_init;
  logic               w_final_beat;
  logic               w_beat_xfer;
  logic [KeepW-1:0]   w_final_keep;

  assign w_s_cmd      = mem_cmd_t'(bus.s_cmd_data);
  // 33-bit sum so len up to 2^32-1 rounds up without overflow.
  assign w_beats_init = 27'(({1'b0, w_s_cmd.len} + 33'd63) >> 6);
  assign w_final_beat = (r_beats_left == 27'd1);
  assign w_final_keep = last_keep(r_cmd.len);
  assign w_beat_xfer  = bus.s_data_valid && bus.m_data_ready;

  // Payload and ids are pure passthrough/registered fields.
  assign bus.m_data_data = bus.s_data_data;
  assign bus.m_data_dest = r_dest;
  assign bus.m_cmd_data  = r_cmd;
  assign bus.m_cmd_dest  = r_dest;

  always_ff @(posedge net_clk) begin
    if (net_reset) begin
      r_state      <= StIdle;
      r_cmd        <= '0;
      r_dest       <= '0;
      r_beats_left <= '0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cmd        <= w_cmd_next;
      r_dest       <= w_dest_next;
      r_beats_left <= w_beats_next;
      r_err_short  <= w_err_short_next;
      r_err_long   <= w_err_long_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cmd_next       = r_cmd;
    w_dest_next      = r_dest;
    w_beats_next     = r_beats_left;
    w_err_short_next = 1'b0;
    w_err_long_next  = 1'b0;

    bus.s_cmd_ready  = 1'b0;
    bus.s_data_ready = 1'b0;
    bus.m_cmd_valid  = 1'b0;
    bus.m_data_valid = 1'b0;
    bus.m_data_last  = 1'b0;
    bus.m_data_keep  = bus.s_data_keep;

    unique case (r_state)
      StIdle: begin
        bus.s_cmd_ready = 1'b1;
        if (bus.s_cmd_valid) begin
          w_cmd_next   = w_s_cmd;
          w_dest_next  = bus.s_cmd_dest;
          w_beats_next = w_beats_init;
          // Zero-length commands are consumed without any downstream traffic.
          if (w_s_cmd.len != 32'd0) begin
            w_state_next = StCmd;
          end
        end
      end

      StCmd: begin
        bus.m_cmd_valid = 1'b1;
        if (bus.m_cmd_ready) begin
          w_state_next = StData;
        end
      end

      StData: begin
        bus.m_data_valid = bus.s_data_valid;
        bus.s_data_ready = bus.m_data_ready;
        bus.m_data_last  = w_final_beat || bus.s_data_last;
        if (w_final_beat) begin
          bus.m_data_keep = w_final_keep;
        end
        if (w_beat_xfer) begin
          w_beats_next = r_beats_left - 27'd1;
          if (w_final_beat) begin
            if (bus.s_data_last) begin
              w_state_next = StIdle;
            end else begin
              w_err_long_next = 1'b1;
              w_state_next    = StDrain;
            end
          end else if (bus.s_data_last) begin
            // Early TLAST: the DMA length stays over-stated; report only.
            w_err_short_next = 1'b1;
            w_state_next     = StIdle;
          end
        end
      end

      StDrain: begin
        bus.s_data_ready = 1'b1;
        if (bus.s_data_valid && bus.s_data_last) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Reset wins over the combinational handshakes so an aborted burst
    // leaks nothing during the reset cycle.
    if (net_reset) begin
      bus.s_cmd_ready  = 1'b0;
      bus.s_data_ready = 1'b0;
      bus.m_cmd_valid  = 1'b0;
      bus.m_data_valid = 1'b0;
      bus.m_data_last  = 1'b0;
    end
  end

  assign err_short = r_err_short && !net_reset;
  assign err_long  = r_err_long && !net_reset;

`ifdef ROCE_WR_STATS_EN
  logic [31:0] r_cmd_count;
  logic [31:0] r_err_count;

  always_ff @(posedge net_clk) begin
    if (net_reset) begin
      r_cmd_count <= '0;
      r_err_count <= '0;
    end else begin
      if (bus.s_cmd_valid && bus.s_cmd_ready && (r_cmd_count != '1)) begin
        r_cmd_count <= r_cmd_count + 32'd1;
      end
      if ((r_err_short || r_err_long) && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 32'd1;
      end
    end
  end

  assign cmd_count = r_cmd_count;
  assign err_count = r_err_count;
`else
  assign cmd_count = 32'd0;
  assign err_count = 32'd0;
`endif

endmodule
